// File: rtl/multi_channel_delay_gen.sv
// Trigger-locked multi-channel pulse delay generator.
// Define DG_TRIG_SYNC_EN to add a 2-flop synchronizer on trig.
module multi_channel_delay_gen #(
  parameter int NCH = 4,
  parameter int CW  = 16,
  parameter int AW  = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  input  logic           trig,
  input  logic           cfg_we,
  input  logic [AW-1:0]  cfg_addr,
  input  logic           cfg_sel,
  input  logic [CW-1:0]  cfg_data,
  output logic [NCH-1:0] ch_out,
  output logic           busy
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [CW-1:0] SAT = '1;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0] r_dly_s [NCH];
  logic [CW-1:0] r_wid_s [NCH];
  logic [CW-1:0] r_dly_a [NCH];
  logic [CW-1:0] r_wid_a [NCH];
  logic [CW-1:0] r_cnt;
  logic          r_trig_d;

  logic          w_trig;
  logic          w_accept;
  logic          w_run;
  logic          w_done;
  logic [CW:0]   w_sum [NCH];
  logic [CW:0]   w_end;
  logic [CW-1:0] w_end_c;
  logic [NCH-1:0] w_ch;
  logic          w_busy;

`ifdef DG_TRIG_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[0], trig};
  end

  assign w_trig = r_sync[1];
`else
  assign w_trig = trig;
`endif

  assign w_run    = (r_state == S_RUN);
  assign w_accept = enable & w_trig & ~r_trig_d;

  always_comb begin
    w_end = '0;
    for (int i = 0; i < NCH; i++) begin
      w_sum[i] = {1'b0, r_dly_a[i]} + {1'b0, r_wid_a[i]};
      if (w_sum[i] > w_end) w_end = w_sum[i];
    end
  end

  // A sequence longer than the counter range ends at saturation
  assign w_end_c = w_end[CW] ? SAT : w_end[CW-1:0];
  assign w_done  = (r_cnt == w_end_c);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) w_next = S_RUN;
      S_RUN: begin
        if (!enable)                w_next = S_IDLE;
        else if (!w_accept && w_done) w_next = S_IDLE;
      end
    endcase
  end

  // Outputs drop on a retrigger edge so every channel re-times cleanly
  always_comb begin
    w_busy = w_run & enable;
    w_ch   = '0;
    for (int i = 0; i < NCH; i++) begin
      w_ch[i] = w_busy & ~w_accept
              & (r_cnt >= r_dly_a[i])
              & ({1'b0, r_cnt} < w_sum[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_trig_d <= 1'b0;
      r_cnt    <= '0;
      ch_out   <= '0;
      busy     <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_trig_d <= w_trig;
      ch_out   <= w_ch;
      busy     <= w_busy;
      if (w_accept)
        r_cnt <= '0;
      else if (w_busy && r_cnt != SAT)
        r_cnt <= r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        r_dly_s[i] <= '0;
        r_wid_s[i] <= '0;
        r_dly_a[i] <= '0;
        r_wid_a[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (w_accept) begin
          r_dly_a[i] <= r_dly_s[i];
          r_wid_a[i] <= r_wid_s[i];
        end
        if (cfg_we && cfg_addr == AW'(i)) begin
          if (cfg_sel) r_wid_s[i] <= cfg_data;
          else         r_dly_s[i] <= cfg_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_channel_delay_gen.sv
// Bench for multi_channel_delay_gen: directed scenarios plus random traffic,
// two instances (NCH=4/CW=16 and NCH=1/CW=4) against a timeline model.
module tb_multi_channel_delay_gen;

`ifdef DG_TRIG_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        trig;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic        cfg_sel;
  logic [15:0] cfg_data;
  logic [3:0]  ch_out;
  logic        busy;
  logic [0:0]  ch_s;
  logic        busy_s;

  multi_channel_delay_gen #(.NCH(4), .CW(16), .AW(2)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .trig(trig),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_sel(cfg_sel),
    .cfg_data(cfg_data), .ch_out(ch_out), .busy(busy)
  );

  multi_channel_delay_gen #(.NCH(1), .CW(4), .AW(1)) u_sml (
    .clk(clk), .rst(rst), .enable(enable), .trig(trig),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr[0:0]), .cfg_sel(cfg_sel),
    .cfg_data(cfg_data[3:0]), .ch_out(ch_s), .busy(busy_s)
  );

  initial forever #5 clk = ~clk;

  int cyc;
  int n_cmp;
  int n_err;
  bit tq [4];
  int sh_d [2][4];
  int sh_w [2][4];
  int ac_d [2][4];
  int ac_w [2][4];
  bit run  [2];
  int ta   [2];
  bit [3:0] e_ch [2];
  bit e_busy [2];

  // Timeline model: counter value is derived from cycles since the accepted edge.
  task automatic model_step();
    bit x, prev, acc, was;
    int c, emax, nch, sat, a, dat;
    bit [3:0] ch;
    for (int j = 3; j > 0; j--) tq[j] = tq[j-1];
    tq[0] = rst ? 1'b0 : trig;
    if (rst) for (int j = 0; j < 4; j++) tq[j] = 1'b0;
    x    = tq[LAT];
    prev = tq[LAT+1];
    for (int k = 0; k < 2; k++) begin
      nch = (k == 0) ? 4 : 1;
      sat = (k == 0) ? 65535 : 15;
      if (rst) begin
        for (int j = 0; j < 4; j++) begin
          sh_d[k][j] = 0; sh_w[k][j] = 0;
          ac_d[k][j] = 0; ac_w[k][j] = 0;
        end
        run[k] = 1'b0; e_ch[k] = '0; e_busy[k] = 1'b0;
      end else begin
        acc = enable && x && !prev;
        was = run[k];
        c = cyc - 1 - ta[k];
        if (c > sat) c = sat;
        emax = 0;
        for (int j = 0; j < nch; j++)
          if (ac_d[k][j] + ac_w[k][j] > emax) emax = ac_d[k][j] + ac_w[k][j];
        if (emax > sat) emax = sat;
        e_busy[k] = was && enable;
        ch = '0;
        if (was && enable && !acc)
          for (int j = 0; j < nch; j++)
            if (c >= ac_d[k][j] && c < ac_d[k][j] + ac_w[k][j]) ch[j] = 1'b1;
        e_ch[k] = ch;
        if (acc) begin
          for (int j = 0; j < 4; j++) begin
            ac_d[k][j] = sh_d[k][j];
            ac_w[k][j] = sh_w[k][j];
          end
          ta[k] = cyc;
          run[k] = 1'b1;
        end else if (was && (!enable || c == emax)) begin
          run[k] = 1'b0;
        end
        if (cfg_we) begin
          a   = (k == 0) ? int'(cfg_addr) : int'(cfg_addr[0]);
          dat = (k == 0) ? int'(cfg_data) : int'(cfg_data[3:0]);
          if (a < nch) begin
            if (cfg_sel) sh_w[k][a] = dat;
            else         sh_d[k][a] = dat;
          end
        end
      end
    end
  endtask

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
      model_step();
    end
  end

  task automatic cfg_wr(input int a, input bit s, input int d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 2'(a); cfg_sel = s; cfg_data = 16'(d);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (ch_out !== 4'b0 || busy !== 1'b0 || ch_s !== 1'b0 || busy_s !== 1'b0) begin
        n_err++;
        $display("FAIL reset got ch=%b busy=%b sch=%b sbusy=%b want zeros",
                 ch_out, busy, ch_s, busy_s);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int d[4] = '{10, 15, 20, 23};
    int w[4] = '{10, 15, 20, 1};
    int er[4] = '{11, 16, 21, 24};
    int rise[4] = '{-1, -1, -1, -1};
    int fall[4] = '{-1, -1, -1, -1};
    int t0, off, bfall;
    bit bseen;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cfg_wr(i, 1'b0, d[i]);
      cfg_wr(i, 1'b1, w[i]);
    end
    bfall = -1; bseen = 1'b0;
    @(negedge clk);
    trig = 1'b1; t0 = cyc + 1;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      off = cyc - t0;
      n_cmp++;
      if (ch_out !== e_ch[0][3:0] || busy !== e_busy[0] ||
          ch_s[0] !== e_ch[1][0] || busy_s !== e_busy[1]) begin
        n_err++;
        $display("FAIL basic cyc=%0d got %b/%b %b/%b want %b/%b %b/%b", cyc,
                 ch_out, busy, ch_s, busy_s, e_ch[0], e_busy[0], e_ch[1][0], e_busy[1]);
      end
      for (int i = 0; i < 4; i++) begin
        if (ch_out[i] && rise[i] < 0) rise[i] = off;
        if (!ch_out[i] && rise[i] >= 0 && fall[i] < 0) fall[i] = off;
      end
      if (busy) bseen = 1'b1;
      else if (bseen && bfall < 0) bfall = off;
      if (t == 3) trig = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (rise[i] != er[i] + LAT || fall[i] - rise[i] != w[i]) begin
        n_err++;
        $display("FAIL basic_ch%0d rise=%0d width=%0d want rise=%0d width=%0d",
                 i, rise[i], fall[i] - rise[i], er[i] + LAT, w[i]);
      end
    end
    n_cmp++;
    if (bfall != 42 + LAT) begin
      n_err++;
      $display("FAIL basic_busy fall=%0d want %0d", bfall, 42 + LAT);
    end
  endtask

  task automatic test_retrigger();
    int t0, r2;
    r2 = -1;
    @(negedge clk);
    trig = 1'b1; t0 = cyc + 1;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      n_cmp++;
      if (ch_out !== e_ch[0][3:0] || busy !== e_busy[0] ||
          ch_s[0] !== e_ch[1][0] || busy_s !== e_busy[1]) begin
        n_err++;
        $display("FAIL retrig cyc=%0d got %b/%b %b/%b want %b/%b %b/%b", cyc,
                 ch_out, busy, ch_s, busy_s, e_ch[0], e_busy[0], e_ch[1][0], e_busy[1]);
      end
      if (t == 12 + LAT) begin
        n_cmp++;
        if (ch_out[0] !== 1'b1) begin
          n_err++;
          $display("FAIL retrig_pre ch0=%b want 1", ch_out[0]);
        end
      end
      if (t == 13 + LAT) begin
        n_cmp++;
        if (ch_out[0] !== 1'b0) begin
          n_err++;
          $display("FAIL retrig_drop ch0=%b want 0", ch_out[0]);
        end
      end
      if (t > 13 + LAT && ch_out[0] && r2 < 0) r2 = t;
      if (t == 2)  trig = 1'b0;
      if (t == 12) trig = 1'b1;
      if (t == 15) trig = 1'b0;
    end
    n_cmp++;
    if (r2 != 24 + LAT) begin
      n_err++;
      $display("FAIL retrig_rise got=%0d want=%0d", r2, 24 + LAT);
    end
  endtask

  task automatic test_shadow();
    int t0, r1;
    for (int pass = 0; pass < 2; pass++) begin
      r1 = -1;
      @(negedge clk);
      trig = 1'b1; t0 = cyc + 1;
      for (int t = 0; t < 60; t++) begin
        @(negedge clk);
        n_cmp++;
        if (ch_out !== e_ch[0][3:0] || busy !== e_busy[0] ||
            ch_s[0] !== e_ch[1][0] || busy_s !== e_busy[1]) begin
          n_err++;
          $display("FAIL shadow cyc=%0d got %b/%b %b/%b want %b/%b %b/%b", cyc,
                   ch_out, busy, ch_s, busy_s, e_ch[0], e_busy[0], e_ch[1][0], e_busy[1]);
        end
        if (ch_out[1] && r1 < 0) r1 = cyc - t0;
        if (t == 2) trig = 1'b0;
        if (pass == 0 && t == 3) begin
          cfg_we = 1'b1; cfg_addr = 2'd1; cfg_sel = 1'b0; cfg_data = 16'd5;
        end
        if (t == 4) cfg_we = 1'b0;
      end
      n_cmp++;
      if (r1 != ((pass == 0) ? 16 : 6) + LAT) begin
        n_err++;
        $display("FAIL shadow_rise pass=%0d got=%0d want=%0d",
                 pass, r1, ((pass == 0) ? 16 : 6) + LAT);
      end
    end
  endtask

  task automatic test_saturate();
    int t0, rs, fs, bf;
    rs = -1; fs = -1; bf = -1;
    cfg_wr(0, 1'b0, 14);
    cfg_wr(0, 1'b1, 5);
    @(negedge clk);
    trig = 1'b1; t0 = cyc + 1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      n_cmp++;
      if (ch_out !== e_ch[0][3:0] || busy !== e_busy[0] ||
          ch_s[0] !== e_ch[1][0] || busy_s !== e_busy[1]) begin
        n_err++;
        $display("FAIL sat cyc=%0d got %b/%b %b/%b want %b/%b %b/%b", cyc,
                 ch_out, busy, ch_s, busy_s, e_ch[0], e_busy[0], e_ch[1][0], e_busy[1]);
      end
      if (ch_s[0] && rs < 0) rs = t;
      if (!ch_s[0] && rs >= 0 && fs < 0) fs = t;
      if (!busy_s && t > 1 && bf < 0) bf = t;
      if (t == 2) trig = 1'b0;
    end
    n_cmp++;
    if (rs != 15 + LAT || fs != 17 + LAT || bf != 17 + LAT) begin
      n_err++;
      $display("FAIL sat_small rise=%0d fall=%0d bfall=%0d want %0d/%0d/%0d",
               rs, fs, bf, 15 + LAT, 17 + LAT, 17 + LAT);
    end
  endtask

  task automatic test_abort();
    @(negedge clk);
    trig = 1'b1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      n_cmp++;
      if (ch_out !== e_ch[0][3:0] || busy !== e_busy[0] ||
          ch_s[0] !== e_ch[1][0] || busy_s !== e_busy[1]) begin
        n_err++;
        $display("FAIL abort cyc=%0d got %b/%b %b/%b want %b/%b %b/%b", cyc,
                 ch_out, busy, ch_s, busy_s, e_ch[0], e_busy[0], e_ch[1][0], e_busy[1]);
      end
      if (t == LAT + 8) begin
        n_cmp++;
        if (busy !== 1'b1 || ch_out[1] !== 1'b1) begin
          n_err++;
          $display("FAIL abort_pre busy=%b ch1=%b want 1/1", busy, ch_out[1]);
        end
        enable = 1'b0;
      end
      if (t == LAT + 9) begin
        n_cmp++;
        if (ch_out !== 4'b0 || busy !== 1'b0) begin
          n_err++;
          $display("FAIL abort_stop ch=%b busy=%b want 0000/0", ch_out, busy);
        end
      end
      if (t > LAT + 17) begin
        n_cmp++;
        if (busy !== 1'b0 || busy_s !== 1'b0) begin
          n_err++;
          $display("FAIL abort_nostart busy=%b sbusy=%b want 0/0", busy, busy_s);
        end
      end
      if (t == 2)        trig = 1'b0;
      if (t == LAT + 11) trig = 1'b1;
      if (t == LAT + 16) enable = 1'b1;
    end
    trig = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    trig = 1'b1;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      n_cmp++;
      if (ch_out !== e_ch[0][3:0] || busy !== e_busy[0] ||
          ch_s[0] !== e_ch[1][0] || busy_s !== e_busy[1]) begin
        n_err++;
        $display("FAIL rstmid cyc=%0d got %b/%b %b/%b want %b/%b %b/%b", cyc,
                 ch_out, busy, ch_s, busy_s, e_ch[0], e_busy[0], e_ch[1][0], e_busy[1]);
      end
      if (t == 16) begin
        n_cmp++;
        if (ch_out !== 4'b0 || busy !== 1'b0 || ch_s !== 1'b0 || busy_s !== 1'b0) begin
          n_err++;
          $display("FAIL rstmid_clear ch=%b busy=%b sch=%b sbusy=%b want zeros",
                   ch_out, busy, ch_s, busy_s);
        end
        rst = 1'b0;
      end
      if (t == 18 + LAT) begin
        n_cmp++;
        if (busy !== 1'b1 || busy_s !== 1'b1) begin
          n_err++;
          $display("FAIL rstmid_start busy=%b sbusy=%b want 1/1", busy, busy_s);
        end
      end
      if (t == 19 + LAT) begin
        n_cmp++;
        if (busy !== 1'b0 || busy_s !== 1'b0 || ch_out !== 4'b0) begin
          n_err++;
          $display("FAIL rstmid_zero busy=%b sbusy=%b ch=%b want 0/0/0000",
                   busy, busy_s, ch_out);
        end
      end
      if (t == 2)  trig = 1'b0;
      if (t == 15) begin rst = 1'b1; trig = 1'b1; end
      if (t == 22) trig = 1'b0;
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      n_cmp++;
      if (ch_out !== e_ch[0][3:0] || busy !== e_busy[0] ||
          ch_s[0] !== e_ch[1][0] || busy_s !== e_busy[1]) begin
        n_err++;
        $display("FAIL random cyc=%0d got %b/%b %b/%b want %b/%b %b/%b", cyc,
                 ch_out, busy, ch_s, busy_s, e_ch[0], e_busy[0], e_ch[1][0], e_busy[1]);
      end
      rst      = ($urandom_range(0, 399) == 0);
      enable   = ($urandom_range(0, 29) != 0);
      trig     = ($urandom_range(0, 19) == 0);
      cfg_we   = ($urandom_range(0, 2) == 0);
      cfg_addr = 2'($urandom_range(0, 3));
      cfg_sel  = 1'($urandom_range(0, 1));
      cfg_data = 16'($urandom_range(0, 20));
    end
    rst = 1'b0; cfg_we = 1'b0; trig = 1'b0; enable = 1'b1;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; trig = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_sel = 1'b0; cfg_data = '0;
    n_cmp = 0; n_err = 0;
    test_reset();
    test_basic();
    test_retrigger();
    test_shadow();
    test_saturate();
    test_abort();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
